// File: rtl/gift_enc_round_control.sv
`default_nettype none
// ============================================================================
//  Module      : gift_enc_round_control
//  Description : Iterative-round controller for the GIFT-64/128 encryption
//                datapath. Accepts host key/data writes, sequences ROUNDS
//                rounds (one per clock), generates the 6-bit round constant
//                and strobes the ciphertext output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module gift_enc_round_control #(
   parameter int ROUNDS = 28,
   parameter int CNT_W  = 8
) (
   input  logic             inClk,
   input  logic             inRst,
   input  logic             inExtKeyWr,
   input  logic             inExtDataWr,
   output logic             outIntKeyschRegExtWr,
   output logic             outIntRoundRegExtWr,
   output logic             outIntRoundRegIntWr,
   output logic             outIntKeyschRegIntWr,
   output logic [5:0]       outRoundConst,
   output logic [CNT_W-1:0] outRoundNum,
   output logic             outIntDataOutRegWr,
   output logic             outBusy,
   output logic             outDone,
   output logic             outKeyStale
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST_ROUND = CNT_W'(ROUNDS);
   localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);
   localparam logic [5:0]       C_LFSR_SEED  = 6'h01;

   // The counter must be able to hold the final round index
   generate
      if ((2 ** CNT_W) <= ROUNDS) begin : g_cntWidthCheck
         $error("CNT_W too narrow for ROUNDS");
      end
   endgenerate

   state_t           r_state;
   logic [CNT_W-1:0] r_roundCnt;
   logic [5:0]       r_lfsr;
   logic             r_keyStale;
   logic             r_done;

   logic w_idle;
   logic w_run;
   logic w_out;

   // Control FSM, round counter, round-constant LFSR and status flags
   always_ff @(posedge inClk) begin
      if (inRst) begin
         r_state    <= ST_IDLE;
         r_roundCnt <= '0;
         r_lfsr     <= 6'h00;
         r_keyStale <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // Counter and LFSR hold their values while idle
               if (inExtKeyWr) begin
                  r_keyStale <= 1'b0;
               end
               if (inExtDataWr) begin
                  r_state    <= ST_RUN;
                  r_roundCnt <= C_ONE;
                  r_lfsr     <= C_LFSR_SEED;
               end
            end
            ST_RUN: begin
               r_roundCnt <= r_roundCnt + C_ONE;
               r_lfsr     <= {r_lfsr[4:0], ~(r_lfsr[5] ^ r_lfsr[4])};
               if (r_roundCnt == C_LAST_ROUND) begin
                  r_state <= ST_OUT;
               end
            end
            ST_OUT: begin
               // Key register has now been consumed by this block
               r_keyStale <= 1'b1;
               r_done     <= 1'b1;
               r_state    <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Output decode: host writes pass through only while idle
   always_comb begin
      w_idle = (r_state == ST_IDLE);
      w_run  = (r_state == ST_RUN);
      w_out  = (r_state == ST_OUT);

      outIntKeyschRegExtWr = w_idle & inExtKeyWr;
      outIntRoundRegExtWr  = w_idle & inExtDataWr;
      outIntRoundRegIntWr  = w_run;
      outIntKeyschRegIntWr = w_run;
      outRoundConst        = w_run ? r_lfsr : 6'h00;
      outRoundNum          = w_run ? r_roundCnt : '0;
      outIntDataOutRegWr   = w_out;
      outBusy              = w_run | w_out;
      outDone              = r_done;
      outKeyStale          = r_keyStale;
   end

endmodule
`default_nettype wire

// File: tb/tb_gift_enc_round_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gift_enc_round_control
//  Description : Self-checking bench for gift_enc_round_control. A 28-round
//                instance is checked through an expected-event scoreboard;
//                a 40-round instance is checked with directed comparisons.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gift_enc_round_control;

   localparam int C_CNT_W = 8;
   localparam int C_R28   = 28;
   localparam int C_R40   = 40;

   // Reference GIFT round constants, rounds 1..40
   logic [5:0] rcTab [0:39] = '{
      6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
      6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
      6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
      6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
   };

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   // 28-round instance signals
   logic               keyWr = 1'b0;
   logic               dataWr = 1'b0;
   logic               ksExtWr, rrExtWr, rrIntWr, ksIntWr;
   logic [5:0]         roundConst;
   logic [C_CNT_W-1:0] roundNum;
   logic               dataOutWr, busy, done, keyStale;

   // 40-round instance signals
   logic               d40KeyWr = 1'b0;
   logic               d40DataWr = 1'b0;
   logic               d40KsExtWr, d40RrExtWr, d40RrIntWr, d40KsIntWr;
   logic [5:0]         d40RoundConst;
   logic [C_CNT_W-1:0] d40RoundNum;
   logic               d40DataOutWr, d40Busy, d40Done, d40KeyStale;

   typedef struct {
      int         cyc;
      int         num;
      logic [5:0] rc;
   } roundExp_t;

   roundExp_t roundQ [$];
   int        outQ   [$];
   int        doneQ  [$];

   int nCompared = 0;
   int nMismatch = 0;

   gift_enc_round_control #(.ROUNDS(C_R28), .CNT_W(C_CNT_W)) dut (
      .inClk                (clk),
      .inRst                (rst),
      .inExtKeyWr           (keyWr),
      .inExtDataWr          (dataWr),
      .outIntKeyschRegExtWr (ksExtWr),
      .outIntRoundRegExtWr  (rrExtWr),
      .outIntRoundRegIntWr  (rrIntWr),
      .outIntKeyschRegIntWr (ksIntWr),
      .outRoundConst        (roundConst),
      .outRoundNum          (roundNum),
      .outIntDataOutRegWr   (dataOutWr),
      .outBusy              (busy),
      .outDone              (done),
      .outKeyStale          (keyStale)
   );

   gift_enc_round_control #(.ROUNDS(C_R40), .CNT_W(C_CNT_W)) dut40 (
      .inClk                (clk),
      .inRst                (rst),
      .inExtKeyWr           (d40KeyWr),
      .inExtDataWr          (d40DataWr),
      .outIntKeyschRegExtWr (d40KsExtWr),
      .outIntRoundRegExtWr  (d40RrExtWr),
      .outIntRoundRegIntWr  (d40RrIntWr),
      .outIntKeyschRegIntWr (d40KsIntWr),
      .outRoundConst        (d40RoundConst),
      .outRoundNum          (d40RoundNum),
      .outIntDataOutRegWr   (d40DataOutWr),
      .outBusy              (d40Busy),
      .outDone              (d40Done),
      .outKeyStale          (d40KeyStale)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nCompared++;
      if (obs !== exp) begin
         nMismatch++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tickN(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Expected events for a 28-round run started by a data write in cycle t
   task automatic pushRun(input int t, input int nRounds, input bit complete);
      roundExp_t e;
      for (int r = 1; r <= nRounds; r++) begin
         e.cyc = t + r;
         e.num = r;
         e.rc  = rcTab[r-1];
         roundQ.push_back(e);
      end
      if (complete) begin
         outQ.push_back(t + C_R28 + 1);
         doneQ.push_back(t + C_R28 + 2);
      end
   endtask

   // Scoreboard monitor for the 28-round instance, sampled mid-cycle
   always @(negedge clk) begin
      roundExp_t e;
      int        x;
      if (rrIntWr) begin
         if (roundQ.size() == 0) begin
            checkVal("unexpRound", rrIntWr, 0);
         end else begin
            e = roundQ.pop_front();
            checkVal("roundCyc", cyc, e.cyc);
            checkVal("roundNum", roundNum, e.num);
            checkVal("roundConst", roundConst, e.rc);
            checkVal("ksIntWr", ksIntWr, 1);
         end
      end
      if (dataOutWr) begin
         if (outQ.size() == 0) begin
            checkVal("unexpOutWr", dataOutWr, 0);
         end else begin
            x = outQ.pop_front();
            checkVal("outWrCyc", cyc, x);
         end
      end
      if (done) begin
         if (doneQ.size() == 0) begin
            checkVal("unexpDone", done, 0);
         end else begin
            x = doneQ.pop_front();
            checkVal("doneCyc", cyc, x);
         end
      end
   end

   initial begin
      int t;
      int busyCnt;

      // Reset
      rst = 1'b1;
      tickN(2);
      rst = 1'b0;
      #1;
      checkVal("rstBusy", busy, 0);
      checkVal("rstRoundNum", roundNum, 0);
      checkVal("rstConst", roundConst, 0);
      checkVal("rstDone", done, 0);
      checkVal("rstKeyStale", keyStale, 0);
      checkVal("rstOutWr", dataOutWr, 0);
      checkVal("rstIntWr", {rrIntWr, ksIntWr}, 0);
      checkVal("rstExtWr", {ksExtWr, rrExtWr}, 0);

      // Run 1: key and data written together
      t = cyc;
      keyWr  = 1'b1;
      dataWr = 1'b1;
      #1;
      checkVal("extKsWr", ksExtWr, 1);
      checkVal("extRrWr", rrExtWr, 1);
      pushRun(t, C_R28, 1'b1);
      tick();
      keyWr  = 1'b0;
      dataWr = 1'b0;
      checkVal("busyRun", busy, 1);
      tickN(C_R28);
      checkVal("busyOut", busy, 1);
      checkVal("staleBeforeOut", keyStale, 0);
      tick();
      checkVal("busyAfter", busy, 0);
      checkVal("staleAfterRun", keyStale, 1);

      // Run 2: back-to-back start with stale key, ignored writes mid-run
      t = cyc;
      dataWr = 1'b1;
      #1;
      checkVal("b2bExtRrWr", rrExtWr, 1);
      pushRun(t, C_R28, 1'b1);
      tick();
      dataWr = 1'b0;
      tickN(4);
      keyWr  = 1'b1;
      dataWr = 1'b1;
      #1;
      checkVal("busyExtKsWr", ksExtWr, 0);
      checkVal("busyExtRrWr", rrExtWr, 0);
      checkVal("busyMid", busy, 1);
      tick();
      keyWr  = 1'b0;
      dataWr = 1'b0;
      tickN(24);
      checkVal("busyAfter2", busy, 0);
      checkVal("staleAfterRun2", keyStale, 1);
      keyWr = 1'b1;
      #1;
      checkVal("idleExtKsWr", ksExtWr, 1);
      tick();
      keyWr = 1'b0;
      checkVal("staleCleared", keyStale, 0);

      // Run 3: reset in the middle aborts with no output write or done
      t = cyc;
      dataWr = 1'b1;
      pushRun(t, 10, 1'b0);
      tick();
      dataWr = 1'b0;
      tickN(9);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkVal("abortBusy", busy, 0);
      checkVal("abortRoundNum", roundNum, 0);
      checkVal("abortConst", roundConst, 0);
      checkVal("abortDone", done, 0);
      tickN(35);

      // 40-round instance
      t = cyc;
      d40DataWr = 1'b1;
      #1;
      checkVal("r40ExtRrWr", d40RrExtWr, 1);
      tick();
      d40DataWr = 1'b0;
      busyCnt = 0;
      for (int r = 1; r <= C_R40; r++) begin
         checkVal("r40RoundNum", d40RoundNum, r);
         checkVal("r40Const", d40RoundConst, rcTab[r-1]);
         if (d40Busy) busyCnt++;
         tick();
      end
      checkVal("r40OutWrCyc", cyc, t + C_R40 + 1);
      checkVal("r40OutWr", d40DataOutWr, 1);
      if (d40Busy) busyCnt++;
      tick();
      checkVal("r40Done", d40Done, 1);
      checkVal("r40BusyEnd", d40Busy, 0);
      checkVal("r40BusyCycles", busyCnt, C_R40 + 1);

      // Every expected event must have been consumed
      tickN(2);
      checkVal("roundQLeft", roundQ.size(), 0);
      checkVal("outQLeft", outQ.size(), 0);
      checkVal("doneQLeft", doneQ.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
`default_nettype wire
